// File: rtl/gate_lu_pkg.sv
// Shared definitions for the gate logic unit: opcodes, FSM states, width bounds
// and the two primitive cells the gate networks are allowed to use.
package gate_lu_pkg;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 8;

    localparam logic [2:0] OP_NOT  = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    localparam bit BASE_NAND = 1'b0;
    localparam bit BASE_NOR  = 1'b1;

    typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

    function automatic logic nand2(input logic p, input logic q);
        return ~(p & q);
    endfunction

    function automatic logic nor2(input logic p, input logic q);
        return ~(p | q);
    endfunction

endpackage

// File: rtl/gate_network.sv
// Combinational bitwise logic unit built from a single universal cell type:
// BASE_NAND uses only 2-input NAND cells, BASE_NOR only 2-input NOR cells.
module gate_network
    import gate_lu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter bit BASE  = BASE_NAND
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // 2:1 mux realised in the network's own cell type.
    function automatic logic mux2(input logic s, input logic d0, input logic d1);
        logic m0, m1;
        if (BASE == BASE_NAND) begin
            return nand2(nand2(d0, nand2(s, s)), nand2(d1, s));
        end else begin
            m0 = nor2(nor2(d0, d0), s);
            m1 = nor2(nor2(d1, d1), nor2(s, s));
            return nor2(nor2(m0, m1), nor2(m0, m1));
        end
    endfunction

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic       na, nb, nab, x1, x2, t;
        logic [7:0] f;
        logic [3:0] l1;
        logic [1:0] l2;

        if (BASE == BASE_NAND) begin : g_nand
            assign na  = nand2(a[i], a[i]);
            assign nb  = nand2(b[i], b[i]);
            assign nab = nand2(a[i], b[i]);
            assign x1  = nand2(a[i], nab);
            assign x2  = nand2(b[i], nab);
            assign t   = nand2(na, nb);           // a | b
            assign f[OP_NOT]  = na;
            assign f[OP_AND]  = nand2(nab, nab);
            assign f[OP_OR]   = t;
            assign f[OP_NAND] = nab;
            assign f[OP_NOR]  = nand2(t, t);
            assign f[OP_XOR]  = nand2(x1, x2);
            assign f[OP_XNOR] = nand2(f[OP_XOR], f[OP_XOR]);
            assign f[OP_PASS] = nand2(na, na);
        end else begin : g_nor
            assign na  = nor2(a[i], a[i]);
            assign nb  = nor2(b[i], b[i]);
            assign nab = nor2(a[i], b[i]);
            assign x1  = nor2(a[i], nab);
            assign x2  = nor2(b[i], nab);
            assign t   = nor2(na, nb);            // a & b
            assign f[OP_NOT]  = na;
            assign f[OP_AND]  = t;
            assign f[OP_OR]   = nor2(nab, nab);
            assign f[OP_NAND] = nor2(t, t);
            assign f[OP_NOR]  = nab;
            assign f[OP_XNOR] = nor2(x1, x2);
            assign f[OP_XOR]  = nor2(f[OP_XNOR], f[OP_XNOR]);
            assign f[OP_PASS] = nor2(na, na);
        end

        for (genvar k = 0; k < 4; k++) begin : g_l1
            assign l1[k] = mux2(op[0], f[2*k], f[2*k+1]);
        end
        for (genvar k = 0; k < 2; k++) begin : g_l2
            assign l2[k] = mux2(op[1], l1[2*k], l1[2*k+1]);
        end
        assign y[i] = mux2(op[2], l2[0], l2[1]);
    end

endmodule

// File: rtl/gate_logic_unit.sv
// Registered bitwise logic unit with NAND/NOR dual networks and a self-test
// sequencer that sweeps every {op, a, b} and counts network disagreements.
module gate_logic_unit
    import gate_lu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 base_sel,
    input  logic                 start,
    input  logic                 fault_inj,
    output logic [WIDTH-1:0]     y,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH+3:0]   err_count,
    output logic                 err_flag,
    output logic [2*WIDTH+2:0]   first_err_vec
);

    localparam int VW = 3 + 2 * WIDTH;
    localparam int CW = VW + 1;
    localparam logic [VW-1:0] V_LAST  = '1;
    localparam logic [CW-1:0] ERR_MAX = '1;

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("gate_logic_unit: WIDTH out of range");
    end

    state_e           state_q, state_d;
    logic [VW-1:0]    v_q, v_d;
    logic             cmp_valid_q, cmp_valid_d;
    logic             cmp_mis_q, cmp_mis_d;
    logic             cmp_last_q, cmp_last_d;
    logic [VW-1:0]    cmp_vec_q, cmp_vec_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             out_valid_q, out_valid_d;
    logic [CW-1:0]    err_q, err_d;
    logic [VW-1:0]    first_q, first_d;

    logic [2:0]       net_op;
    logic [WIDTH-1:0] net_a, net_b, nand_y, nor_raw, nor_y;

    // During a sweep both networks see the vector counter instead of the ports.
    always_comb begin
        if (state_q == StSweep) begin
            {net_op, net_a, net_b} = v_q;
        end else begin
            {net_op, net_a, net_b} = {op, a, b};
        end
        nor_y    = nor_raw;
        nor_y[0] = nor_raw[0] ^ fault_inj;
    end

    gate_network #(.WIDTH(WIDTH), .BASE(BASE_NAND)) u_nand (
        .op (net_op),
        .a  (net_a),
        .b  (net_b),
        .y  (nand_y)
    );

    gate_network #(.WIDTH(WIDTH), .BASE(BASE_NOR)) u_nor (
        .op (net_op),
        .a  (net_a),
        .b  (net_b),
        .y  (nor_raw)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StSweep;
            StSweep: if (cmp_last_q) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q != StIdle);
        done = (state_q == StDone);
    end

    always_comb begin
        v_d         = v_q;
        cmp_valid_d = 1'b0;
        cmp_mis_d   = cmp_mis_q;
        cmp_last_d  = 1'b0;
        cmp_vec_d   = cmp_vec_q;
        y_d         = y_q;
        out_valid_d = 1'b0;
        err_d       = err_q;
        first_d     = first_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    v_d     = '0;
                    err_d   = '0;
                    first_d = '0;
                end else if (in_valid) begin
                    y_d         = base_sel ? nor_y : nand_y;
                    out_valid_d = 1'b1;
                end
            end
            StSweep: begin
                // Terminal vector holds the counter; its compare drains next cycle.
                if (!cmp_last_q) begin
                    cmp_valid_d = 1'b1;
                    cmp_mis_d   = (nand_y != nor_y);
                    cmp_vec_d   = v_q;
                    cmp_last_d  = (v_q == V_LAST);
                    if (v_q != V_LAST) v_d = v_q + 1'b1;
                end
            end
            default: ;
        endcase

        if (cmp_valid_q && cmp_mis_q) begin
            if (err_q == '0) first_d = cmp_vec_q;
            if (err_q != ERR_MAX) err_d = err_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q         <= '0;
            cmp_valid_q <= 1'b0;
            cmp_mis_q   <= 1'b0;
            cmp_last_q  <= 1'b0;
            cmp_vec_q   <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            err_q       <= '0;
            first_q     <= '0;
        end else begin
            v_q         <= v_d;
            cmp_valid_q <= cmp_valid_d;
            cmp_mis_q   <= cmp_mis_d;
            cmp_last_q  <= cmp_last_d;
            cmp_vec_q   <= cmp_vec_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            first_q     <= first_d;
        end
    end

    assign y             = y_q;
    assign out_valid     = out_valid_q;
    assign err_count     = err_q;
    assign err_flag      = (err_q != '0);
    assign first_err_vec = first_q;

endmodule
